// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the CPU memory-port arbiter.
// Also used by the memory model so latency settings stay in sync.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT
  } state_t;

  typedef logic owner_t;
  localparam owner_t OWNER_IF = 1'b0;
  localparam owner_t OWNER_LS = 1'b1;

  localparam int MEM_LATENCY_DEF    = 1;
  localparam int MAX_DATA_BURST_DEF = 2;

endpackage

// File: rtl/mem_arb_priority.sv
// Grant pick between fetch and load/store.
// Holds the LS streak counter that bounds fetch starvation.
module mem_arb_priority
  import cpu_mem_pkg::*;
#(
  parameter int MAX_DATA_BURST = MAX_DATA_BURST_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic idle,
  input  logic if_req,
  input  logic ls_req,
  output logic if_gnt,
  output logic ls_gnt
);

  localparam int SW = $clog2(MAX_DATA_BURST + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_DATA_BURST);

  logic [SW-1:0] streak;
  logic          if_turn;

  // IF wins when alone or once LS has used up its burst
  assign if_turn = if_req & (~ls_req | (streak == SMAX));
  assign if_gnt  = idle & if_turn;
  assign ls_gnt  = idle & ls_req & ~if_turn;

  always_ff @(posedge clk) begin
    if (reset) begin
      streak <= '0;
    end else if (if_gnt) begin
      streak <= '0;
    end else if (ls_gnt) begin
      if (!if_req)
        streak <= '0;
      else if (streak != SMAX)
        streak <= streak + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Each grant becomes one ACCESS cycle, plus a WAIT phase for reads.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MEM_LATENCY    = MEM_LATENCY_DEF,
  parameter int MAX_DATA_BURST = MAX_DATA_BURST_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pipeline_stall
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY - 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  owner_t        owner;
  logic          we_q;
  logic          grant;
  logic          last;

  mem_arb_priority #(
    .MAX_DATA_BURST(MAX_DATA_BURST)
  ) u_prio (
    .clk   (clk),
    .reset (reset),
    .idle  (state == IDLE),
    .if_req(if_req),
    .ls_req(ls_req),
    .if_gnt(if_gnt),
    .ls_gnt(ls_gnt)
  );

  assign grant = if_gnt | ls_gnt;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (grant) state_next = ACCESS;
      ACCESS:  state_next = we_q ? IDLE : WAIT;
      WAIT:    if (cnt == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // mem_* double as the captured request; only mem_addr persists
  always_ff @(posedge clk) begin
    if (reset) begin
      owner        <= OWNER_IF;
      we_q         <= 1'b0;
      cnt          <= '0;
      mem_en       <= 1'b0;
      mem_write_en <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      mem_en       <= 1'b0;
      mem_write_en <= 1'b0;
      mem_wdata    <= '0;
      if (grant) begin
        owner        <= ls_gnt ? OWNER_LS : OWNER_IF;
        we_q         <= ls_gnt & ls_we;
        mem_en       <= 1'b1;
        mem_write_en <= ls_gnt & ls_we;
        mem_addr     <= ls_gnt ? ls_addr : if_addr;
        mem_wdata    <= (ls_gnt & ls_we) ? ls_wdata : '0;
      end
      if (state == ACCESS)
        cnt <= CNT_LOAD;
      else if (state == WAIT && cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

  assign last      = (state == WAIT) & (cnt == '0) & ~reset;
  assign if_rvalid = last & (owner == OWNER_IF);
  assign ls_rvalid = last & (owner == OWNER_LS);
  assign if_rdata  = mem_rdata;
  assign ls_rdata  = mem_rdata;

  assign pipeline_stall = if_req & ~if_gnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random traffic against a transaction-level model of the port.
// Includes a dense contention window and random resets.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int L  = 2;
  localparam int B  = 2;
  localparam int NCYC = 3000;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ls_req;
  logic          ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_gnt;
  logic          ls_rvalid;
  logic [DW-1:0] ls_rdata;
  logic          mem_en;
  logic          mem_write_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          pipeline_stall;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .MEM_LATENCY(L),
    .MAX_DATA_BURST(B)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .if_req        (if_req),
    .if_addr       (if_addr),
    .if_gnt        (if_gnt),
    .if_rvalid     (if_rvalid),
    .if_rdata      (if_rdata),
    .ls_req        (ls_req),
    .ls_we         (ls_we),
    .ls_addr       (ls_addr),
    .ls_wdata      (ls_wdata),
    .ls_gnt        (ls_gnt),
    .ls_rvalid     (ls_rvalid),
    .ls_rdata      (ls_rdata),
    .mem_en        (mem_en),
    .mem_write_en  (mem_write_en),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .pipeline_stall(pipeline_stall)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 3))
      0:       a = 32'h100;
      1:       a = 32'h40;
      default: a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    endcase
    return a;
  endfunction

  // Memory: rdata is valid only L cycles after the mem_en cycle
  logic [31:0] tb_mem [logic [31:0]];
  int          rd_cyc = -100;
  logic [31:0] rd_data = '0;
  logic [31:0] junk;

  always_comb begin
    junk = cyc;
    mem_rdata = (cyc == rd_cyc + L) ? rd_data : {junk[15:0], 16'hA5A5};
  end

  // Reference model: transaction timing from grant cycle
  logic [31:0] ref_mem [logic [31:0]];
  int          free_at = 0;
  int          streak  = 0;
  int          acc_cyc = -1;
  int          rv_cyc  = -1;
  logic        acc_we  = 1'b0;
  logic [31:0] acc_wdata = '0;
  logic [31:0] exp_addr  = '0;
  logic [31:0] rv_data   = '0;
  logic        rv_owner  = 1'b0;
  logic        g_if = 1'b0;
  logic        g_ls = 1'b0;

  initial begin
    logic        e_if, e_ls, idle, ev, dense, w;
    logic [31:0] a;
    reset    = 1'b1;
    if_req   = 1'b0;
    ls_req   = 1'b0;
    ls_we    = 1'b0;
    if_addr  = '0;
    ls_addr  = '0;
    ls_wdata = '0;
    tb_mem[32'h100]  = 32'hDEADBEEF;
    ref_mem[32'h100] = 32'hDEADBEEF;

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      cyc   = c;
      dense = (c >= 1200 && c < 1260);
      reset = (c < 2) || (!dense && c > 4 && $urandom_range(0, 79) == 0);

      if (g_if || !if_req) begin
        if_req  = dense || ($urandom_range(0, 2) == 0);
        if_addr = rand_addr();
      end else if (!dense && $urandom_range(0, 15) == 0) begin
        if_req = 1'b0;
      end
      if (g_ls || !ls_req) begin
        ls_req   = dense || ($urandom_range(0, 1) == 0);
        ls_we    = ($urandom_range(0, 2) == 0);
        ls_addr  = rand_addr();
        ls_wdata = $urandom;
      end else if (!dense && $urandom_range(0, 15) == 0) begin
        ls_req = 1'b0;
      end

      idle = (c >= free_at);
      e_if = idle && if_req && (!ls_req || streak == B);
      e_ls = idle && ls_req && !e_if;
      ev   = (c == rv_cyc) && !reset;

      @(negedge clk);
      if (c >= 1) begin
        check("if_gnt", if_gnt, e_if);
        check("ls_gnt", ls_gnt, e_ls);
        check("mem_en", mem_en, c == acc_cyc);
        check("mem_write_en", mem_write_en, (c == acc_cyc) && acc_we);
        check("mem_wdata", mem_wdata, (c == acc_cyc) ? acc_wdata : 32'h0);
        check("mem_addr", mem_addr, exp_addr);
        check("if_rvalid", if_rvalid, ev && !rv_owner);
        check("ls_rvalid", ls_rvalid, ev && rv_owner);
        check("pipeline_stall", pipeline_stall, if_req && !e_if);
        if (ev && !rv_owner) check("if_rdata", if_rdata, rv_data);
        if (ev && rv_owner)  check("ls_rdata", ls_rdata, rv_data);
      end

      if (mem_en === 1'b1) begin
        if (mem_write_en === 1'b1) begin
          tb_mem[mem_addr] = mem_wdata;
        end else begin
          rd_cyc  = c;
          rd_data = tb_mem.exists(mem_addr) ? tb_mem[mem_addr]
                                            : init_word(mem_addr);
        end
      end

      g_if = e_if && !reset;
      g_ls = e_ls && !reset;
      if (reset) begin
        free_at  = c + 1;
        streak   = 0;
        acc_cyc  = -1;
        rv_cyc   = -1;
        exp_addr = '0;
      end else if (g_if || g_ls) begin
        a = g_ls ? ls_addr : if_addr;
        w = g_ls && ls_we;
        if (g_ls)
          streak = if_req ? ((streak < B) ? streak + 1 : B) : 0;
        else
          streak = 0;
        acc_cyc   = c + 1;
        acc_we    = w;
        acc_wdata = w ? ls_wdata : 32'h0;
        exp_addr  = a;
        if (w) begin
          ref_mem[a] = ls_wdata;
          free_at    = c + 2;
        end else begin
          rv_cyc   = c + 1 + L;
          rv_owner = g_ls;
          rv_data  = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
          free_at  = c + 2 + L;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
